// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store controller.
//   XLEN        - datapath width (32)
//   lsu_size_e  - access size encoding; the unused code 3 is handled as a word
//   lsu_state_e - controller FSM states
//   is_word / is_misaligned - size and alignment decode helpers
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } lsu_state_e;

  // Sizes 2 and 3 both behave as a full word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    if (size[1]) begin
      mis = (offset != 2'd0);
    end else if (size == SZ_HALF) begin
      mis = offset[0];
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and data-memory signals of the load/store
// controller.
//   slave  modport - seen by lsu_ctrl (takes requests and mem_rd, drives the rest)
//   master modport - seen by the CPU/memory environment
interface lsu_ctrl_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [XLEN-1:0] mem_a;
  logic [XLEN-1:0] mem_wd;
  logic            mem_we;
  logic [XLEN-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
  );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   mem_rd     in  - word read from data memory
//   wdata      in  - right-aligned store data
//   size       in  - access size (3 treated as word)
//   offset     in  - addr[1:0]; halves use offset[1] only
//   uns        in  - 1 zero-extends loads, 0 sign-extends
//   load_data  out - extracted and extended load result
//   merge_data out - mem_rd with the addressed lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] mem_rd,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            uns,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and extend it to a full word.
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'd0:    byte_s = mem_rd[7:0];
      2'd1:    byte_s = mem_rd[15:8];
      2'd2:    byte_s = mem_rd[23:16];
      2'd3:    byte_s = mem_rd[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_data = mem_rd;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{~uns & half_s[15]}}, half_s};
      default: load_data = mem_rd;
    endcase
  end

  // Replace the addressed lane of the read word with the store data.
  always_comb begin
    merge_data = mem_rd;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data        = mem_rd;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences byte/half/word loads and stores onto a single-port,
// word-wide, synchronous-read data memory. Sub-word stores use
// read-modify-write. Every accepted request gets exactly one response.
//   clk   in - clock, rising edge
//   rst_n in - asynchronous active-low reset
//   bus      - lsu_ctrl_if.slave: req_* handshake, rsp_* completion, mem_* port
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses through the ERR state (rsp_err=1, no memory access). Without it,
// misaligned accesses proceed to the aligned location and rsp_err is 0.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  lsu_state_e      state_r;
  lsu_state_e      state_s;
  logic            we_r;
  logic [1:0]      size_r;
  logic            uns_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wdata_r;
  logic            accept_s;
  logic [XLEN-1:0] word_addr_s;
  logic [XLEN-1:0] load_s;
  logic [XLEN-1:0] merge_s;

  assign accept_s    = bus.req_valid & (state_r == IDLE);
  assign word_addr_s = {addr_r[XLEN-1:2], 2'b00};

  lsu_lane_align u_align (
    .mem_rd     (bus.mem_rd),
    .wdata      (wdata_r),
    .size       (size_r),
    .offset     (addr_r[1:0]),
    .uns        (uns_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch: captured on accept, held until the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'd0;
      uns_r   <= 1'b0;
      addr_r  <= {XLEN{1'b0}};
      wdata_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      size_r  <= bus.req_size;
      uns_r   <= bus.req_unsigned;
      addr_r  <= bus.req_addr;
      wdata_r <= bus.req_wdata;
    end
  end

  // Next-state decode; full-word stores skip the read phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef LSU_MISALIGN_CHECK_EN
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_s = ERR;
          end else if (bus.req_we && is_word(bus.req_size)) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
`else
          if (bus.req_we && is_word(bus.req_size)) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
`endif
        end else begin
          state_s = IDLE;
        end
      end
      READ:    state_s = DATA;
      DATA:    state_s = IDLE;
      WRITE:   state_s = IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
      ERR:     state_s = IDLE;
`endif
      default: state_s = IDLE;
    endcase
  end

  // Port decode from the state register and the latched request.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = {XLEN{1'b0}};
    bus.rsp_err   = 1'b0;
    bus.mem_a     = {XLEN{1'b0}};
    bus.mem_wd    = {XLEN{1'b0}};
    bus.mem_we    = 1'b0;
    case (state_r)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      READ: begin
        bus.mem_a = word_addr_s;
      end
      DATA: begin
        // mem_rd holds the word presented during READ.
        bus.mem_a     = word_addr_s;
        bus.rsp_valid = 1'b1;
        if (we_r) begin
          bus.mem_we = 1'b1;
          bus.mem_wd = merge_s;
        end else begin
          bus.rsp_rdata = load_s;
        end
      end
      WRITE: begin
        bus.mem_a     = word_addr_s;
        bus.mem_we    = 1'b1;
        bus.mem_wd    = wdata_r;
        bus.rsp_valid = 1'b1;
      end
`ifdef LSU_MISALIGN_CHECK_EN
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end
`endif
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. A word-array memory answers
// the DUT's memory port; a separate reference memory plus plain-arithmetic
// load/merge functions produce every expected value.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  int vectors     = 0;
  int miscompares = 0;

  // Synchronous-read, single-port data memory seen by the DUT.
  always @(posedge clk) begin
    if (bus.mem_we) dmem[bus.mem_a[7:2]] <= bus.mem_wd;
    bus.mem_rd <= dmem[bus.mem_a[7:2]];
  end

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] a);
    int sh;
    logic [31:0] v;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return m_mis(sz, a);
`else
    return (sz == 2'd3) && (a == 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  // One request with full latency and memory-side checks.
  task automatic do_req(input string name, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input logic [31:0] exp_wd);
    int lat;
    int exp_lat;
    logic [31:0] exp_a;
    exp_a   = exp_err ? 32'h0 : {a[31:2], 2'b00};
    exp_lat = (exp_err || (we && sz[1])) ? 1 : 2;
    @(negedge clk);
    drive(we, sz, uns, a, wd);
    bus.req_valid = 1'b1;
    chk({name, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    if (exp_lat == 2) begin
      chk({name, " rd_we"}, {31'd0, bus.mem_we}, 32'd0);
      chk({name, " rd_a"}, bus.mem_a, exp_a);
    end
    while (!bus.rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no rsp_valid after %0d cycles, expected %0d", name, lat, exp_lat);
    end else begin
      chk({name, " lat"}, lat, exp_lat);
      chk({name, " rdata"}, bus.rsp_rdata, exp_rd);
      chk({name, " err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
      chk({name, " we"}, {31'd0, bus.mem_we}, {31'd0, we && !exp_err});
      chk({name, " a"}, bus.mem_a, exp_a);
      if (we && !exp_err) chk({name, " wd"}, bus.mem_wd, exp_wd);
    end
    if (we && !exp_err) ref_mem[a[7:2]] = m_merge(ref_mem[a[7:2]], sz, a, wd);
  endtask

  task automatic do_model_req(input string name, input bit we, input logic [1:0] sz,
                              input bit uns, input logic [31:0] a, input logic [31:0] wd);
    bit e;
    logic [31:0] rd;
    e  = m_err(sz, a);
    rd = (we || e) ? 32'h0 : m_load(ref_mem[a[7:2]], sz, uns, a);
    do_req(name, we, sz, uns, a, wd, rd, e, m_merge(ref_mem[a[7:2]], sz, a, wd));
  endtask

  // Three requests with req_valid held high throughout.
  task automatic busy_seq();
    logic [31:0] exp_q [$];
    bit          bw  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  bs  [3] = '{2'd2, 2'd2, 2'd0};
    logic [31:0] ba  [3] = '{32'h10, 32'h14, 32'h15};
    logic [31:0] bd  [3] = '{32'h0, 32'h0BAD_F00D, 32'h0};
    int acc = 0;
    int got = 0;
    bit busy = 1'b0;
    bit acc_last = 1'b0;
    @(negedge clk);
    drive(bw[0], bs[0], 1'b1, ba[0], bd[0]);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (acc_last) begin
        if (acc < 3) drive(bw[acc], bs[acc], 1'b1, ba[acc], bd[acc]);
        else bus.req_valid = 1'b0;
        busy = 1'b1;
        acc_last = 1'b0;
      end
      if (busy) chk("busy ready", {31'd0, bus.req_ready}, 32'd0);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL busy extra rsp: got rdata %08h expected no response", bus.rsp_rdata);
        end else begin
          chk("busy rdata", bus.rsp_rdata, exp_q.pop_front());
        end
        got++;
        busy = 1'b0;
      end
      if (bus.req_valid && bus.req_ready && acc < 3) begin
        exp_q.push_back(bw[acc] ? 32'h0 : m_load(ref_mem[ba[acc][7:2]], bs[acc], 1'b1, ba[acc]));
        if (bw[acc]) ref_mem[ba[acc][7:2]] = m_merge(ref_mem[ba[acc][7:2]], bs[acc], ba[acc], bd[acc]);
        acc++;
        acc_last = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("busy responses", got, 32'd3);
    chk("busy accepts", acc, 32'd3);
  endtask

  // Byte store aborted by reset while in READ.
  task automatic reset_seq();
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0055);
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst in read a", bus.mem_a, 32'h20);
    rst_n = 1'b0;
    #1;
    chk("rst ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst mem_a", bus.mem_a, 32'd0);
    chk("rst mem_wd", bus.mem_wd, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst no rsp", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst no we", {31'd0, bus.mem_we}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst mem unchanged", dmem[8], ref_mem[8]);
    do_model_req("post rst load", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
  endtask

  bit          r_we;
  bit          r_uns;
  logic [1:0]  r_sz;
  logic [31:0] r_a;
  logic [31:0] r_wd;

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 32'h1122_3344};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 32'h0, 1'b0, 32'h11AA_3344};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 32'hFFFF_FFAA, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 32'h0000_00AA, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h30, 32'h8001_7FFE, 32'h0, 1'b0, 32'h8001_7FFE};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hFFFF_8001, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 32'h0000_7FFE, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 32'hCAFE_F00D};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 32'h0};
`else
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0};
`endif
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 2'd1, 1'b1, 32'h32, 32'h0000_5678, 32'h0, 1'b0, 32'h5678_7FFE};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 32'h0000_0056, 1'b0, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h31, 32'hABCD_1234, 32'h0, 1'b1, 32'h0};
`else
    tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h31, 32'hABCD_1234, 32'h0, 1'b0, 32'h5678_1234};
`endif

    bus.req_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("reset ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_wd", bus.mem_wd, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 48; i++) begin
      do_model_req("preload", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
    end

    for (int i = 0; i < 15; i++) begin
      do_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a,
             tbl[i].wd, tbl[i].rd, tbl[i].err, tbl[i].ewd);
    end

    busy_seq();
    reset_seq();

    for (int i = 0; i < 60; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom_range(0, 1));
      r_a   = 32'($urandom_range(0, 191));
      r_wd  = $urandom;
      do_model_req($sformatf("rnd%0d", i), r_we, r_sz, r_uns, r_a, r_wd);
    end

    @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("mem word %0d", i), dmem[i], ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that sequences the CPU's byte/half/word memory accesses onto the single-port, word-wide data memory (synchronous read, one access per cycle, write-or-read). Sub-word stores use read-modify-write; loads extract and sign/zero-extend the addressed lane. Sits between the execute stage and the data memory. Every request gets exactly one response.

## Interface
- No parameters; widths fixed at 32 bits.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — high only in IDLE; accept = `req_valid & req_ready`.
- `req_we` in 1 — 1 store, 0 load.
- `req_size` in 2 — 0 byte, 1 half, 2 word; 3 is reserved and treated as word.
- `req_unsigned` in 1 — zero-extend load (1) or sign-extend (0).
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1 — one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 32 — load result; 0 when `rsp_valid` is low or for stores.
- `rsp_err` out 1 — misaligned access; valid with `rsp_valid`.
- `mem_a` out 32 — word address `{addr[31:2],2'b00}`; 0 in IDLE.
- `mem_wd` out 32 — memory write data.
- `mem_we` out 1 — memory write enable.
- `mem_rd` in 32 — memory read data, valid the cycle after a read is presented.

## Operation
- Accept latches we, size, unsigned, addr and wdata. Latched fields are stable until the response.
- FSM states:
  - IDLE: `req_ready`=1. On accept, go to ERR if misaligned (macro on); else WRITE for a word store; else READ.
  - READ: drive `mem_a`, `mem_we`=0. Go to DATA.
  - DATA: `mem_rd` is valid.
    - Load: `rsp_valid`=1; `rsp_rdata` = selected lane, extended per `req_unsigned`; word loads are passed through.
    - Sub-word store: `mem_we`=1, same `mem_a`, `mem_wd` = `mem_rd` with the addressed lane replaced; `rsp_valid`=1.
    - Go to IDLE.
  - WRITE: `mem_we`=1, `mem_wd`=wdata, `rsp_valid`=1. Go to IDLE.
  - ERR: `rsp_valid`=1, `rsp_err`=1, no memory access. Go to IDLE.
- Lanes are little-endian.
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] or [31:16]).
- `mem_we`=0 in every state except WRITE and sub-word DATA.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, latched fields 0.
- Accept in cycle N. Response arrives:
  - word store / error: cycle N+1;
  - load / sub-word store: cycle N+2.
- The next request can be accepted in the cycle after `rsp_valid` (back-to-back throughput: 1 per 2–3 cycles).
- Outputs are decoded from the state register and the latched request. `rsp_rdata` is combinational from `mem_rd` in DATA.
- `req_valid` held high during a busy state is ignored until IDLE. No request is dropped, because `req_ready` is low.
- Reset mid-operation aborts the access:
  - no response is issued;
  - `mem_we` drops immediately;
  - a partial RMW performs no write if reset is asserted before DATA.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - misaligned requests take the ERR path;
  - there is no memory access;
  - `rsp_err`=1.
- Undefined:
  - `rsp_err` is tied 0 and there is no ERR state;
  - half ignores addr[0]; word ignores addr[1:0];
  - the access proceeds to the aligned location.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - `lsu_state_e` (IDLE, READ, DATA, WRITE, ERR);
  - constant `XLEN=32`.
- Sub-module `lsu_lane_align` is purely combinational:
  - extract + extend: inputs `mem_rd`, size, offset, unsigned;
  - merge: inputs `mem_rd`, wdata, size, offset.
- The FSM, request latch and port decode stay in `lsu_ctrl`.

## Test plan
- Word store, then load: store 0xDEADBEEF @0x10, then load word @0x10.
  - Expect `mem_we` pulse at N+1 with `mem_a`=0x10.
  - Load returns 0xDEADBEEF at N+2.
- Byte RMW: memory @0x20 = 0x11223344; store byte 0xAA @0x22.
  - Read at N+1, write 0x11AA3344 at N+2.
  - Load byte signed @0x22 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half loads: memory @0x30 = 0x8001_7FFE.
  - Signed half @0x32 → 0xFFFF8001.
  - Half @0x30 → 0x00007FFE.
- Misaligned: word load @0x41 with macro on → `rsp_err`=1 at N+1, no `mem_we`, `mem_a` stays 0.
  - Macro off → accesses @0x40, `rsp_err`=0.
- Busy backpressure: hold `req_valid` high across 3 back-to-back requests.
  - Expect `req_ready` low in READ/DATA/WRITE.
  - Exactly 3 responses, in order.
- Reset mid-RMW: assert `rst_n` low during READ of a byte store.
  - No write occurs, memory is unchanged, outputs go to reset values.
  - The first post-reset request completes normally.
